// File: rtl/reg8file_reader.sv
// Read-side sequencer for the 8-entry register file: single reads or wrap-around bursts as a valid/ready stream.
// Optional checksum word after each burst is enabled by defining READER_CHECKSUM_EN.
module reg8file_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic [ADDR_W-1:0] rsel,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              out_csum
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NREGS - 1);

`ifdef READER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEL, HOLD, CSUM} state_t;
  logic [DATA_W-1:0] acc;
`else
  typedef enum logic [1:0] {IDLE, SEL, HOLD} state_t;
`endif

  state_t            state;
  logic              burst;
  logic [ADDR_W-1:0] cnt;

  assign busy = (state != IDLE);

`ifndef READER_CHECKSUM_EN
  assign out_csum = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      rsel      <= '0;
      burst     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
`ifdef READER_CHECKSUM_EN
      acc       <= '0;
      out_csum  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rsel  <= addr;
            burst <= mode;
            cnt   <= '0;
`ifdef READER_CHECKSUM_EN
            acc   <= '0;
`endif
            state <= SEL;
          end
        end

        // rsel has had a full cycle to settle, so rdata is the file contents at this edge.
        SEL: begin
          out_data  <= rdata;
          out_idx   <= rsel;
          out_valid <= 1'b1;
`ifdef READER_CHECKSUM_EN
          acc       <= acc ^ rdata;
          out_last  <= !burst;
`else
          out_last  <= !burst || (cnt == LAST_CNT);
`endif
          state     <= HOLD;
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            if (!burst) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else if (cnt == LAST_CNT) begin
`ifdef READER_CHECKSUM_EN
              // acc already includes the final word captured in SEL.
              out_data  <= acc;
              out_idx   <= '0;
              out_csum  <= 1'b1;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
              state     <= CSUM;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
`endif
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rsel      <= rsel + 1'b1;
              cnt       <= cnt + 1'b1;
              state     <= SEL;
            end
          end
        end

`ifdef READER_CHECKSUM_EN
        CSUM: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_csum  <= 1'b0;
            state     <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg8file_reader.sv
// Scoreboard bench for reg8file_reader with a behavioural register file preloaded with reg i = 1<<i.
// Define READER_CHECKSUM_EN here as well as in the RTL to check the checksum word.
module tb_reg8file_reader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;
`ifdef READER_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif
  localparam int BURST_CYC = 2*NREGS + CSUM_EXTRA;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              csum;
  } word_t;

  logic              clk = 1'b0;
  logic              clrn = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              busy;
  logic [ADDR_W-1:0] rsel;
  logic [DATA_W-1:0] rdata;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              out_csum;

  logic [DATA_W-1:0] regs [NREGS];
  word_t             exp_q [$];
  int                checks = 0;
  int                errors = 0;

  assign rdata = regs[rsel];

  always #5 clk = ~clk;

  reg8file_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .clrn(clrn), .start(start), .mode(mode), .addr(addr),
    .busy(busy), .rsel(rsel), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_csum(out_csum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREGS; i++) regs[i] = 8'h01 << i;
    clrn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, rsel, out_valid, out_data, out_idx, out_last, out_csum} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b rsel=%0d valid=%b data=%h idx=%0d last=%b csum=%b, required all 0",
               busy, rsel, out_valid, out_data, out_idx, out_last, out_csum);
    end
    clrn = 1'b1;
    tick();
    // Mid-idle async pulse, checked before any clock edge arrives.
    clrn = 1'b0;
    #2;
    checks++;
    if ({busy, out_valid, out_data, out_idx, out_last} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b valid=%b data=%h, required 0", busy, out_valid, out_data);
    end
    #1 clrn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int valid_cnt = 0;
    bit done = 1'b0;
    word_t exp_w;
    exp_q.push_back({8'h08, 3'd3, 1'b1, 1'b0});
    mode = 1'b0; addr = 3'd3; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL single_extra_word: got data=%h idx=%0d, required no word", out_data, out_idx);
        end else begin
          exp_w = exp_q.pop_front();
          if (word_t'({out_data, out_idx, out_last, out_csum}) !== exp_w) begin
            errors++;
            $display("[TB] FAIL single_word: got data=%h idx=%0d last=%b csum=%b, required data=%h idx=%0d last=%b csum=%b",
                     out_data, out_idx, out_last, out_csum, exp_w.data, exp_w.idx, exp_w.last, exp_w.csum);
          end
        end
      end
      if (!busy) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL single_timeout: got busy=%b, required idle within 40 cycles", busy); end
    checks++;
    if (busy_cnt !== 2) begin errors++; $display("[TB] FAIL single_busy: got %0d cycles, required 2", busy_cnt); end
    checks++;
    if (valid_cnt !== 1) begin errors++; $display("[TB] FAIL single_valid: got %0d cycles, required 1", valid_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL single_missing: got %0d words left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // Burst from start_addr; if stall_idx >= 0, deassert out_ready for 5 cycles while that index is valid.
  task automatic test_burst(input logic [ADDR_W-1:0] start_addr, input int stall_idx);
    int busy_cnt = 0;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] csum = '0;
    logic [DATA_W-1:0] held_d;
    logic [ADDR_W-1:0] held_i;
    logic [ADDR_W-1:0] a;
    word_t exp_w;
    for (int i = 0; i < NREGS; i++) begin
      a = start_addr + ADDR_W'(i);
      csum ^= regs[a];
      exp_q.push_back({regs[a], a, (i == NREGS-1) && (CSUM_EXTRA == 0), 1'b0});
    end
`ifdef READER_CHECKSUM_EN
    exp_q.push_back({csum, 3'd0, 1'b1, 1'b1});
`endif
    mode = 1'b1; addr = start_addr; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (busy) busy_cnt++;
      if (stall_idx >= 0 && !stalled && out_valid && out_idx == ADDR_W'(stall_idx)) begin
        held_d = 8'h01 << stall_idx;
        held_i = ADDR_W'(stall_idx);
        out_ready = 1'b0;
        stalled = 1'b1;
        for (int s = 0; s < 5; s++) begin
          tick();
          if (busy) busy_cnt++;
          checks++;
          if (out_valid !== 1'b1 || out_data !== held_d || out_idx !== held_i || rsel !== held_i) begin
            errors++;
            $display("[TB] FAIL stall_hold: got valid=%b data=%h idx=%0d rsel=%0d, required valid=1 data=%h idx=%0d rsel=%0d",
                     out_valid, out_data, out_idx, rsel, held_d, held_i, held_i);
          end
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL burst_extra_word: got data=%h idx=%0d, required no word", out_data, out_idx);
        end else begin
          exp_w = exp_q.pop_front();
          if (word_t'({out_data, out_idx, out_last, out_csum}) !== exp_w) begin
            errors++;
            $display("[TB] FAIL burst_word: got data=%h idx=%0d last=%b csum=%b, required data=%h idx=%0d last=%b csum=%b",
                     out_data, out_idx, out_last, out_csum, exp_w.data, exp_w.idx, exp_w.last, exp_w.csum);
          end
        end
      end
      if (!busy) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL burst_timeout: got busy=%b, required idle within 80 cycles", busy); end
    checks++;
    if (busy_cnt !== BURST_CYC + (stall_idx >= 0 ? 5 : 0)) begin
      errors++;
      $display("[TB] FAIL burst_busy: got %0d cycles, required %0d", busy_cnt, BURST_CYC + (stall_idx >= 0 ? 5 : 0));
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL burst_missing: got %0d words left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midburst();
    int accepted = 0;
    word_t exp_w;
    for (int i = 0; i < NREGS; i++) exp_q.push_back({regs[i], ADDR_W'(i), 1'b0, 1'b0});
    mode = 1'b1; addr = 3'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && accepted < 3; c++) begin
      // A restart request in the middle of the burst must be ignored.
      if (c == 2) begin start = 1'b1; mode = 1'b0; addr = 3'd5; end
      else start = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        exp_w = exp_q.pop_front();
        if ({out_data, out_idx} !== {exp_w.data, exp_w.idx}) begin
          errors++;
          $display("[TB] FAIL midburst_word: got data=%h idx=%0d, required data=%h idx=%0d",
                   out_data, out_idx, exp_w.data, exp_w.idx);
        end
        accepted++;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (accepted !== 3) begin errors++; $display("[TB] FAIL midburst_timeout: got %0d words, required 3", accepted); end
    clrn = 1'b0;
    #2;
    checks++;
    if ({busy, rsel, out_valid, out_data, out_idx, out_last, out_csum} !== '0) begin
      errors++;
      $display("[TB] FAIL midburst_reset: got busy=%b rsel=%0d valid=%b data=%h idx=%0d, required all 0",
               busy, rsel, out_valid, out_data, out_idx);
    end
    exp_q.delete();
    #1 clrn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst(3'd5, -1);
    test_burst(3'd0, 2);
    test_reset_midburst();
    test_burst(3'd0, -1);
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
